// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the common data bus between the RS ALU and the load/store buffer.
//   Each producer pushes results into its own circular FIFO through a
//   valid/ready handshake. A round-robin arbiter pops at most one head entry
//   per cycle and registers it onto the broadcast outputs.
//
// Parameters
//   ROB_ID_W   : width of the ROB tag
//   FIFO_DEPTH : entries per source FIFO (power of 2, >= 2)
//
// Ports
//   clk_in                 : clock, all state on the rising edge
//   rst_in                 : asynchronous active-low reset
//   rdy_in                 : global pause when low (every register holds)
//   clear_all              : ROB flush, empties both FIFOs and kills the broadcast
//   alu_valid/rob_id/value : ALU result offer        alu_ready : ALU FIFO can accept
//   lsb_valid/rob_id/value : LSB result offer        lsb_ready : LSB FIFO can accept
//   cdb_valid/rob_id/value : registered broadcast    cdb_src   : 0 = ALU, 1 = LSB
module cdb_arbiter #(
  parameter int ROB_ID_W   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_all,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [31:0]         alu_value,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_value,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [31:0]         cdb_value,
  output logic                cdb_src
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Index 0 is the ALU FIFO, index 1 the LSB FIFO (matches cdb_src encoding).
  logic [ROB_ID_W-1:0] tag_mem_r [2][FIFO_DEPTH];
  logic [31:0]         val_mem_r [2][FIFO_DEPTH];
  logic [PTR_W-1:0]    head_r    [2];
  logic [PTR_W-1:0]    tail_r    [2];
  logic [CNT_W-1:0]    count_r   [2];
  logic                last_grant_r;

  logic                cdb_valid_r;
  logic [ROB_ID_W-1:0] cdb_rob_id_r;
  logic [31:0]         cdb_value_r;
  logic                cdb_src_r;

  logic [1:0]          in_valid_s;
  logic [ROB_ID_W-1:0] in_tag_s [2];
  logic [31:0]         in_val_s [2];
  logic [1:0]          ready_s;
  logic [1:0]          nonempty_s;
  logic [1:0]          push_s;
  logic [1:0]          pop_s;
  logic                grant_s;
  logic                winner_s;
  logic [ROB_ID_W-1:0] head_tag_s;
  logic [31:0]         head_val_s;

  assign alu_ready  = ready_s[0];
  assign lsb_ready  = ready_s[1];
  assign cdb_valid  = cdb_valid_r;
  assign cdb_rob_id = cdb_rob_id_r;
  assign cdb_value  = cdb_value_r;
  assign cdb_src    = cdb_src_r;

  // Handshake: ready depends only on the registered count, so a pop this
  // cycle never frees a slot for a push in the same cycle.
  always_comb begin
    in_valid_s  = {lsb_valid, alu_valid};
    in_tag_s[0] = alu_rob_id;
    in_tag_s[1] = lsb_rob_id;
    in_val_s[0] = alu_value;
    in_val_s[1] = lsb_value;
    ready_s     = 2'b00;
    nonempty_s  = 2'b00;
    push_s      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ready_s[i]    = rdy_in & (count_r[i] != FULL_CNT);
      nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
      push_s[i]     = in_valid_s[i] & ready_s[i] & ~clear_all;
    end
  end

  // Round-robin choice: on a tie the source that did not win last goes.
  always_comb begin
    winner_s = 1'b0;
    if (nonempty_s[0] & nonempty_s[1]) begin
      winner_s = ~last_grant_r;
    end else if (nonempty_s[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    grant_s    = rdy_in & ~clear_all & (|nonempty_s);
    pop_s      = {grant_s & winner_s, grant_s & ~winner_s};
    head_tag_s = tag_mem_r[winner_s][head_r[winner_s]];
    head_val_s = val_mem_r[winner_s][head_r[winner_s]];
  end

  // FIFO storage: written only on an accepted push, contents need no reset.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        tag_mem_r[i][tail_r[i]] <= in_tag_s[i];
        val_mem_r[i][tail_r[i]] <= in_val_s[i];
      end
    end
  end

  // FIFO pointers and counts; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 2; i++) begin
        head_r[i]  <= {PTR_W{1'b0}};
        tail_r[i]  <= {PTR_W{1'b0}};
        count_r[i] <= {CNT_W{1'b0}};
      end
    end else if (rdy_in) begin
      for (int i = 0; i < 2; i++) begin
        if (clear_all) begin
          head_r[i]  <= {PTR_W{1'b0}};
          tail_r[i]  <= {PTR_W{1'b0}};
          count_r[i] <= {CNT_W{1'b0}};
        end else begin
          if (push_s[i]) tail_r[i] <= tail_r[i] + PTR_W'(1);
          if (pop_s[i])  head_r[i] <= head_r[i] + PTR_W'(1);
          case ({push_s[i], pop_s[i]})
            2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
            2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
            default: count_r[i] <= count_r[i];
          endcase
        end
      end
    end
  end

  // Broadcast registers and round-robin history; a flush leaves last_grant alone.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_r  <= 1'b0;
      cdb_rob_id_r <= {ROB_ID_W{1'b0}};
      cdb_value_r  <= 32'h0000_0000;
      cdb_src_r    <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (rdy_in) begin
      if (clear_all) begin
        cdb_valid_r <= 1'b0;
      end else if (grant_s) begin
        cdb_valid_r  <= 1'b1;
        cdb_rob_id_r <= head_tag_s;
        cdb_value_r  <= head_val_s;
        cdb_src_r    <= winner_s;
        last_grant_r <= winner_s;
      end else begin
        cdb_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the two result producers in the out-of-order core: the reservation-station ALU and the load/store buffer. Each producer pushes completed results into a private FIFO through a valid/ready handshake. A round-robin arbiter pops one result per cycle and broadcasts it to ROB, RS and LSB wake-up logic. This removes the current same-cycle RS/LSB broadcast collision and the wake-up loss on the consumer side.

## Interface
- `ROB_ID_W`, 4: width of ROB tag.
- `FIFO_DEPTH`, 2: entries per source FIFO; power of 2, at least 2.

- `clk_in` in 1: clock, all state on rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global pause when low.
- `clear_all` in 1: ROB flush (mispredict).
- `alu_valid` in 1: ALU result offered.
- `alu_rob_id` in ROB_ID_W: ALU result tag.
- `alu_value` in 32: ALU result value.
- `alu_ready` out 1: ALU FIFO can accept.
- `lsb_valid` in 1: LSB result offered.
- `lsb_rob_id` in ROB_ID_W: LSB result tag.
- `lsb_value` in 32: LSB result value.
- `lsb_ready` out 1: LSB FIFO can accept.
- `cdb_valid` out 1: broadcast valid, one cycle per result.
- `cdb_rob_id` out ROB_ID_W: broadcast tag.
- `cdb_value` out 32: broadcast value.
- `cdb_src` out 1: 0 = ALU, 1 = LSB.

## Operation
- Two independent circular FIFOs: head pointer, tail pointer, count of width clog2(FIFO_DEPTH+1). Pointers wrap modulo FIFO_DEPTH.
- Ready: `x_ready = rdy_in & (count_x != FIFO_DEPTH)`. This is combinational from registered count only. A pop in the same cycle does not raise ready.
- Push: on an edge with `x_valid & x_ready & !clear_all`, write tag and value at the tail and increment tail. Valid with ready low is ignored. The producer holds or retries.
- Arbitration state: `last_grant` (0 = ALU, 1 = LSB).
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source not equal to `last_grant`.
  - Neither non-empty: no grant.
  - Eligibility uses the count at the start of the cycle. An entry pushed this edge cannot be granted this edge.
- Grant on an edge: pop the winner's head and increment head. Register the head entry onto `cdb_rob_id`/`cdb_value`, set `cdb_src` to the winner, set `cdb_valid <= 1`, set `last_grant <=` winner.
- No grant: `cdb_valid <= 0`. The cdb data registers hold their previous values.
- Push and pop on the same FIFO in the same edge: both take effect and count is unchanged.
- `clear_all` (with `rdy_in` high) has priority over everything:
  - both counts, heads and tails go to 0;
  - `cdb_valid <= 0`;
  - pushes and grants on that edge are discarded;
  - `last_grant` is unchanged.
- `rdy_in` low: every register holds, including `cdb_valid`. Ready outputs are 0.
- Async reset (`rst_in` low), effective immediately, independent of the clock:
  - all counts and pointers 0;
  - `last_grant = 1` (ALU wins the first tie);
  - `cdb_valid = 0`, `cdb_rob_id = 0`, `cdb_value = 0`, `cdb_src = 0`.
  - Reset mid-operation discards all queued results.

## Timing
- Latency: result accepted at edge E0 appears with `cdb_valid = 1` after edge E1, provided it wins. Minimum latency is 2 cycles from valid presented to broadcast visible.
- Throughput: 1 broadcast per cycle total. Under continuous contention the sources alternate ALU, LSB, ALU, and so on. Worst-case wait for a head entry is 1 cycle.
- `cdb_valid` is a single-cycle pulse per result. Back-to-back pulses are allowed with a new tag each cycle.
- A full FIFO drops ready in the cycle after the filling push. A producer asserting valid into a full FIFO loses nothing, because no push occurs.

## Test plan
- Reset: hold `rst_in = 0` mid-clock, then release. Required: all cdb outputs 0, `alu_ready = lsb_ready = 1` with `rdy_in = 1`.
- Single ALU result: tag 3, value 0x1234 pushed at E0. Required: after E1, `cdb_valid = 1`, id 3, value 0x1234, src 0; after E2, `cdb_valid = 0`.
- Contention: both sources push every cycle (ALU tags 1,2; LSB tags 9,10). Required broadcast order: 1(ALU), 9(LSB), 2(ALU), 10(LSB), on consecutive cycles.
- Full/backpressure: two LSB pushes with no grants possible (preload plus `rdy_in` toggle). Required: `lsb_ready = 0` at count 2. A third valid is not enqueued, and only 2 broadcasts follow.
- Flush: queue 2 ALU and 1 LSB entry, pulse `clear_all`. Required: `cdb_valid = 0` next cycle, no further broadcasts, both ready = 1. The push offered on the flush edge does not appear.
- Pause: `rdy_in = 0` for 3 cycles with `cdb_valid = 1` (tag 5). Required: outputs frozen at tag 5, ready = 0. On resume, the next queued entry broadcasts.
